dds_phase_gen: RTL and testbench
================================

DDS_PHASE_GEN -- requirements
Module: dds_phase_gen

Interface
REQ-001 Parameter PHASE_W, 16, phase accumulator width in bits.
REQ-002 Parameter ADDR_W, 6, sine ROM address width; addr = top ADDR_W bits of phase.
REQ-003 Parameter DIV_W, 8, prescaler divide-value width.
REQ-004 Parameter FTW_RST, 1024, frequency tuning word after reset.
REQ-005 Parameter DIV_RST, 2, prescaler divide value after reset (tick every DIV+1 cycles).
REQ-006 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  sample-rate clock (300 MHz PLL domain), all logic on rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 en  in  1  run enable; low = generator idle.
REQ-010 phase_clr  in  1  synchronous pulse: zero phase accumulator.
REQ-011 cfg_valid  in  1  new configuration offered.
REQ-012 cfg_ready  out  1  configuration accepted when cfg_valid and cfg_ready both high.
REQ-013 cfg_ftw  in  PHASE_W  new tuning word.
REQ-014 cfg_div  in  DIV_W  new prescaler divide value.
REQ-015 tick  out  1  one-cycle ROM/DAC enable strobe.
REQ-016 addr  out  ADDR_W  ROM address, valid and stable while tick high, held otherwise.
REQ-017 wrap  out  1  one-cycle pulse, coincident with tick, when the accumulator overflowed.

Function
REQ-018 States: IDLE (en low), RUN, PEND (config captured, not yet applied); state type held in package.
REQ-019 IDLE->RUN when en high; RUN/PEND->IDLE when en low; RUN->PEND on accepted config; PEND->RUN on next tick.
REQ-020 cfg_ready high in IDLE and RUN, low in PEND.
REQ-021 Config accepted in IDLE applies to ftw_q/div_q on the next edge; accepted in RUN is shadowed and applies at the next tick.
REQ-022 Prescaler counts 0..div_q while in RUN/PEND; tick asserted the cycle after count reaches div_q, then count restarts at 0; div_q=0 gives tick every cycle.
REQ-023 On each tick edge phase <= phase + ftw (modulo 2^PHASE_W, carry discarded); addr and wrap registered from the result, so addr is valid in the tick cycle.
REQ-024 In PEND the tick applying the new ftw uses the new value for that accumulation; new div_q governs the following interval.
REQ-025 wrap = carry out of the PHASE_W-bit addition for that tick.
REQ-026 en low: tick, wrap low next cycle; prescaler cleared to 0; phase and addr held; pending config applied immediately.
REQ-027 phase_clr: phase and addr zeroed next cycle; if coincident with tick, clear wins and no accumulation occurs, tick still asserted with addr=0.
REQ-028 cfg_valid held while cfg_ready low shall not alter state; first accepted value wins.
REQ-029 ftw=0: tick continues, addr constant, wrap never asserted.

Reset
REQ-030 rst_n low: state IDLE, phase 0, addr 0, tick 0, wrap 0, prescaler 0, ftw_q=FTW_RST, div_q=DIV_RST, shadow cleared, cfg_ready 1 after release.
REQ-031 Reset mid-RUN or mid-PEND discards any pending config; first tick after release and en high occurs DIV_RST+1 cycles later.

Structure
REQ-032 Package sine_pkg holds PHASE_W, ADDR_W, DIV_W defaults and the state enum (IDLE, RUN, PEND).
REQ-033 Prescaler is a sub-module tick_prescaler (clk, rst_n, en, div, tick); accumulator, FSM and config shadow stay in the top.

Verification
REQ-034 Reset release, en=1, defaults -> first tick 3 cycles after en, ticks every 3 cycles, addr sequence 0x01,0x02,... (1024/1024), wrap on 64th tick with addr 0x00.
REQ-035 cfg div=0, ftw=0x8000 in IDLE, en=1 -> tick every cycle, addr alternates 0x20,0x00, wrap on every second tick.
REQ-036 cfg ftw=2048 accepted in RUN -> cfg_ready low until next tick; that tick advances addr by 2; cfg_valid held during PEND ignored.
REQ-037 phase_clr coincident with tick -> addr=0x00, wrap=0; next tick addr=0x01.
REQ-038 en dropped mid-interval -> no tick, addr held; en re-raised -> first tick div_q+1 cycles later continuing from held phase.
REQ-039 rst_n asserted in PEND -> all outputs zero immediately, ftw_q=1024 after release, pending config lost.

Source files
------------

// File: rtl/sine_pkg.sv
// Shared defaults and the generator state type for the DDS phase generator.
package sine_pkg;

  localparam int PHASE_W_DEF = 16;
  localparam int ADDR_W_DEF  = 6;
  localparam int DIV_W_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } dds_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..div counter; tick is a combinational "count reached div"
// strobe that the top registers together with the phase update.
module tick_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    // >= keeps the counter bounded if div is lowered mid-interval
    tick  = en && (cnt_q >= div);
    cnt_d = cnt_q;
    if (!en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dds_phase_gen.sv
// DDS phase accumulator with prescaled tick, run/idle FSM and a config shadow
// that lets a new tuning word land exactly on the next tick.
module dds_phase_gen
  import sine_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int FTW_RST = 1024,
  parameter int DIV_RST = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               phase_clr,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_ftw,
  input  logic [DIV_W-1:0]   cfg_div,
  output logic               tick,
  output logic [ADDR_W-1:0]  addr,
  output logic               wrap,
  output dds_state_e         dbg_state
);

  // Config handshake: a word transfers on a rising edge where cfg_valid and
  // cfg_ready are both high; cfg_ready is low only while a word is pending.

  dds_state_e         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               tick_q, tick_d;
  logic               wrap_q, wrap_d;
  logic [PHASE_W-1:0] ftw_q, ftw_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [PHASE_W-1:0] sh_ftw_q, sh_ftw_d;
  logic [DIV_W-1:0]   sh_div_q, sh_div_d;

  logic               pre_tick;
  logic               cfg_acc;
  logic [PHASE_W-1:0] ftw_eff;
  logic [PHASE_W:0]   sum;

  tick_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .div   (div_q),
    .tick  (pre_tick)
  );

  assign cfg_ready = (state_q != PEND);
  assign cfg_acc   = cfg_valid && cfg_ready;
  // The tick that retires a pending word already accumulates with it
  assign ftw_eff   = (state_q == PEND) ? sh_ftw_q : ftw_q;
  assign sum       = {1'b0, phase_q} + {1'b0, ftw_eff};

  always_comb begin
    phase_d = phase_q;
    addr_d  = addr_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (pre_tick) begin
      tick_d  = 1'b1;
      phase_d = sum[PHASE_W-1:0];
      wrap_d  = sum[PHASE_W];
      addr_d  = sum[PHASE_W-1 -: ADDR_W];
    end
    if (phase_clr) begin
      phase_d = '0;
      addr_d  = '0;
      wrap_d  = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    ftw_d    = ftw_q;
    div_d    = div_q;
    sh_ftw_d = sh_ftw_q;
    sh_div_d = sh_div_q;
    case (state_q)
      IDLE: begin
        if (cfg_acc) begin
          ftw_d = cfg_ftw;
          div_d = cfg_div;
        end
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          if (cfg_acc) begin
            ftw_d = cfg_ftw;
            div_d = cfg_div;
          end
        end else if (cfg_acc) begin
          sh_ftw_d = cfg_ftw;
          sh_div_d = cfg_div;
          state_d  = PEND;
        end
      end
      PEND: begin
        if (!en || pre_tick) begin
          ftw_d   = sh_ftw_q;
          div_d   = sh_div_q;
          state_d = en ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      addr_q   <= '0;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
      ftw_q    <= PHASE_W'(FTW_RST);
      div_q    <= DIV_W'(DIV_RST);
      sh_ftw_q <= '0;
      sh_div_q <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      addr_q   <= addr_d;
      tick_q   <= tick_d;
      wrap_q   <= wrap_d;
      ftw_q    <= ftw_d;
      div_q    <= div_d;
      sh_ftw_q <= sh_ftw_d;
      sh_div_q <= sh_div_d;
    end
  end

  assign tick      = tick_q;
  assign addr      = addr_q;
  assign wrap      = wrap_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed + random bench for dds_phase_gen against a countdown-style reference model.
module tb_dds_phase_gen;
  import sine_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        phase_clr;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_ftw;
  logic [7:0]  cfg_div;
  logic        tick;
  logic [5:0]  addr;
  logic        wrap;
  dds_state_e  dbg_state;

  int n_assert;
  int n_fail;

  // reference model state
  int m_phase;
  int m_ftw;
  int m_div;
  int m_pend;
  int m_pftw;
  int m_pdiv;
  int m_active;
  int m_left;
  int exp_tick;
  int exp_addr;
  int exp_wrap;

  dds_phase_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .phase_clr (phase_clr),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ftw   (cfg_ftw),
    .cfg_div   (cfg_div),
    .tick      (tick),
    .addr      (addr),
    .wrap      (wrap),
    .dbg_state (dbg_state)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_phase = 0; m_ftw = 1024; m_div = 2; m_pend = 0;
    m_pftw = 0; m_pdiv = 0; m_active = 0; m_left = 0;
    exp_tick = 0; exp_addr = 0; exp_wrap = 0;
  endfunction

  // One rising edge of the generator, computed from the rules directly:
  // m_left is the number of enabled edges still to go before the next tick.
  function automatic void model_step();
    int accept;
    int use_ftw;
    int total;
    accept   = cfg_valid && !m_pend;
    exp_tick = 0;
    exp_wrap = 0;
    if (en) begin
      if (m_left <= 0) m_left = m_div + 1;
      m_left--;
      if (m_left == 0) exp_tick = 1;
    end else begin
      m_left = 0;
    end
    use_ftw = m_pend ? m_pftw : m_ftw;
    if (exp_tick) begin
      total    = m_phase + use_ftw;
      exp_wrap = (total >= 65536);
      m_phase  = total % 65536;
    end
    if (phase_clr) begin
      m_phase  = 0;
      exp_wrap = 0;
    end
    if (exp_tick || phase_clr) exp_addr = m_phase / 1024;
    if (!en) begin
      if (m_pend) begin m_ftw = m_pftw; m_div = m_pdiv; end
      m_pend = 0;
      if (accept) begin m_ftw = cfg_ftw; m_div = cfg_div; end
    end else if (!m_active) begin
      if (accept) begin m_ftw = cfg_ftw; m_div = cfg_div; end
    end else if (m_pend) begin
      if (exp_tick) begin m_ftw = m_pftw; m_div = m_pdiv; m_pend = 0; end
    end else if (accept) begin
      m_pend = 1; m_pftw = cfg_ftw; m_pdiv = cfg_div;
    end
    m_active = en;
  endfunction

  // driver: advance one edge, update model, compare all outputs
  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    chk("tick", tick, exp_tick);
    chk("addr", addr, exp_addr);
    chk("wrap", wrap, exp_wrap);
    chk("cfg_ready", cfg_ready, !m_pend);
  endtask

  task automatic expect_first_tick(input string tag, input int n);
    int c;
    c = 0;
    step();
    c++;
    while (!tick && c < 20) begin
      step();
      c++;
    end
    chk(tag, c, n);
  endtask

  task automatic wait_tick(input string tag);
    int c;
    c = 0;
    step();
    c++;
    while (!tick && c < 20) begin
      step();
      c++;
    end
    chk(tag, tick, 1);
  endtask

  task automatic load_cfg(input logic [15:0] f, input logic [7:0] d);
    en = 0; cfg_valid = 1; cfg_ftw = f; cfg_div = d; phase_clr = 1;
    step();
    cfg_valid = 0; phase_clr = 0;
  endtask

  initial begin
    int held;
    int c;
    n_assert = 0; n_fail = 0;
    rst_n = 0; en = 0; phase_clr = 0; cfg_valid = 0; cfg_ftw = '0; cfg_div = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tick", tick, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_ready", cfg_ready, 1);
    rst_n = 1;
    step();

    // defaults: tick every 3 cycles, addr counts by one, wrap on 64th tick
    en = 1;
    expect_first_tick("first_tick_latency", 3);
    chk("seq_addr_1", addr, 1);
    for (int k = 2; k <= 64; k++) begin
      repeat (3) step();
      chk("seq_addr", addr, k % 64);
      chk("seq_wrap", wrap, (k == 64));
    end

    // div=0, half-scale tuning word
    en = 0;
    step();
    load_cfg(16'h8000, 8'd0);
    en = 1;
    step(); chk("half_a0", addr, 6'h20); chk("half_w0", wrap, 0);
    step(); chk("half_a1", addr, 6'h00); chk("half_w1", wrap, 1);
    step(); chk("half_a2", addr, 6'h20);
    repeat (5) step();

    // config accepted while running lands on the next tick
    en = 0;
    step();
    load_cfg(16'd1024, 8'd2);
    en = 1;
    expect_first_tick("run_first_tick", 3);
    step();
    cfg_valid = 1; cfg_ftw = 16'd2048; cfg_div = 8'd2;
    step();
    chk("pend_ready", cfg_ready, 0);
    cfg_ftw = 16'h1234;
    wait_tick("pend_tick");
    chk("pend_tick_addr", addr, 3);
    cfg_valid = 0;
    repeat (3) step();
    chk("after_pend_addr", addr, 5);

    // phase_clr on the tick edge
    en = 0;
    step();
    load_cfg(16'd1024, 8'd2);
    en = 1;
    step();
    c = 0;
    while (m_left != 1 && c < 20) begin step(); c++; end
    phase_clr = 1;
    step();
    phase_clr = 0;
    chk("clr_tick", tick, 1);
    chk("clr_addr", addr, 0);
    chk("clr_wrap", wrap, 0);
    repeat (3) step();
    chk("clr_next_addr", addr, 1);

    // en dropped mid-interval, then resumed
    step();
    held = m_phase / 1024;
    en = 0;
    repeat (4) step();
    chk("idle_hold_addr", addr, held);
    en = 1;
    expect_first_tick("resume_latency", 3);
    chk("resume_addr", addr, (held + 1) % 64);

    // reset while a config is pending
    cfg_valid = 1; cfg_ftw = 16'd4096; cfg_div = 8'd5;
    step();
    cfg_valid = 0;
    chk("pre_rst_pend", cfg_ready, 0);
    rst_n = 0; en = 0;
    #1;
    chk("arst_tick", tick, 0);
    chk("arst_addr", addr, 0);
    chk("arst_wrap", wrap, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    step();
    en = 1;
    expect_first_tick("post_rst_latency", 3);
    chk("post_rst_addr", addr, 1);
    repeat (6) step();

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      en        = ($urandom_range(0, 15) != 0);
      phase_clr = ($urandom_range(0, 31) == 0);
      cfg_valid = ($urandom_range(0, 7) == 0) && !(en && !m_active);
      cfg_ftw   = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 65535));
      cfg_div   = 8'($urandom_range(0, 4));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
